// File: rtl/red_pitaya_dsp_seq_pkg.sv
// Shared types for the DSP bus command sequencer: FSM states, queued command
// record and the byte-select pattern driven on every bus access.
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    localparam logic [3:0] SYS_SEL = 4'hF;

endpackage

// File: rtl/red_pitaya_dsp_seq_if.sv
// Push/pop channel between the sequencer FSM and its command FIFO.
// valid/ready: a transfer happens on a clock edge where both are high; valid never waits on ready.
interface red_pitaya_dsp_seq_if;
    import dsp_seq_pkg::*;

    logic push_valid;
    logic push_ready;
    cmd_t push_data;
    logic pop_valid;
    logic pop_ready;
    cmd_t pop_data;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );

endinterface

// File: rtl/red_pitaya_dsp_seq_fifo.sv
// Synchronous show-ahead command FIFO, DEPTH entries (power of two), with
// natural pointer wrap. A push is refused while full even if a pop coincides.
module dsp_seq_fifo
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    red_pitaya_dsp_seq_if.slave   q
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = q.push_valid && !full;
    assign pop   = q.pop_ready && !empty;

    assign q.push_ready = !full;
    assign q.pop_valid  = !empty;
    assign q.pop_data   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= q.push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/red_pitaya_dsp_seq.sv
// Queued bus-command sequencer: FIFO of read/write commands replayed one at a time
// on the sys bus. Define DSP_SEQ_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module red_pitaya_dsp_seq
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] sys_addr_o,
    output logic [31:0] sys_wdata_o,
    output logic [3:0]  sys_sel_o,
    output logic        sys_wen_o,
    output logic        sys_ren_o,
    input  logic [31:0] sys_rdata_i,
    input  logic        sys_err_i,
    input  logic        sys_ack_i,
    output state_t      dbg_state_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("red_pitaya_dsp_seq: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    red_pitaya_dsp_seq_if fifo_bus ();

    state_t state;
    logic   cur_we;

    assign fifo_bus.push_valid = cmd_valid_i;
    assign fifo_bus.push_data  = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    assign fifo_bus.pop_ready  = (state == ST_IDLE);
    assign cmd_ready_o         = fifo_bus.push_ready;
    assign dbg_state_o         = state;

    dsp_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .q      (fifo_bus)
    );

`ifdef DSP_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            cur_we      <= 1'b0;
            sys_addr_o  <= '0;
            sys_wdata_o <= '0;
            sys_sel_o   <= '0;
            sys_wen_o   <= 1'b0;
            sys_ren_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
`ifdef DSP_SEQ_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_bus.pop_valid) begin
                        cur_we      <= fifo_bus.pop_data.we;
                        sys_addr_o  <= fifo_bus.pop_data.addr;
                        sys_wdata_o <= fifo_bus.pop_data.wdata;
                        sys_sel_o   <= SYS_SEL;
                        sys_wen_o   <= fifo_bus.pop_data.we;
                        sys_ren_o   <= !fifo_bus.pop_data.we;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sys_wen_o <= 1'b0;
                    sys_ren_o <= 1'b0;
`ifdef DSP_SEQ_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // err wins over a simultaneous ack, and discards any read data
                    if (sys_err_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                        sys_sel_o   <= '0;
                        state       <= ST_RESP;
                    end else if (sys_ack_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= cur_we ? 32'h0 : sys_rdata_i;
                        sys_sel_o   <= '0;
                        state       <= ST_RESP;
                    end
`ifdef DSP_SEQ_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                        sys_sel_o   <= '0;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_red_pitaya_dsp_seq.sv
// Self-checking bench for red_pitaya_dsp_seq: randomized commands, a bus responder
// model and an in-order response scoreboard. Timeout scenario needs DSP_SEQ_TIMEOUT_EN.
module tb_red_pitaya_dsp_seq;
    import dsp_seq_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;
    localparam int M_ACK   = 0;
    localparam int M_ERR   = 1;
    localparam int M_BOTH  = 2;
    localparam int M_NONE  = 3;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          mode;
        int          delay;
    } tcmd_t;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;
    state_t      dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wait_cyc = 0;
    logic        stall = 1'b0;
    state_t      prev_state = ST_IDLE;
    tcmd_t       cmd_q[$];
    tcmd_t       plan_q[$];
    tcmd_t       cur;
    logic [33:0] exp_q[$];

    red_pitaya_dsp_seq #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .sys_addr_o  (sys_addr),
        .sys_wdata_o (sys_wdata),
        .sys_sel_o   (sys_sel),
        .sys_wen_o   (sys_wen),
        .sys_ren_o   (sys_ren),
        .sys_rdata_i (sys_rdata),
        .sys_err_i   (sys_err),
        .sys_ack_i   (sys_ack),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // monitor: issue check, address stability, response scoreboard
    always @(negedge clk) begin
        if (rstn) begin
            if (sys_wen || sys_ren) begin
                n_cmp++;
                if (cmd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_unexpected: wen=%b ren=%b addr=%h, required no access", sys_wen, sys_ren, sys_addr);
                end else begin
                    tcmd_t c;
                    logic [33:0] e;
                    c = cmd_q.pop_front();
                    cur = c;
                    if ({sys_wen, sys_ren, sys_sel, sys_addr, (c.we ? sys_wdata : 32'h0)} !==
                        {c.we, !c.we, 4'hF, c.addr, (c.we ? c.wdata : 32'h0)}) begin
                        n_err++;
                        $display("FAIL issue: wen=%b ren=%b sel=%h addr=%h wdata=%h, required wen=%b ren=%b sel=f addr=%h wdata=%h",
                                 sys_wen, sys_ren, sys_sel, sys_addr, sys_wdata, c.we, !c.we, c.addr, c.wdata);
                    end
                    case (c.mode)
                        M_ACK:   e = {2'b00, (c.we ? 32'h0 : c.rdata)};
                        M_NONE:  e = {2'b11, 32'h0};
                        default: e = {2'b01, 32'h0};
                    endcase
`ifdef DSP_SEQ_TIMEOUT_EN
                    exp_q.push_back(e);
`else
                    if (c.mode != M_NONE) exp_q.push_back(e);
`endif
                    plan_q.push_back(c);
                end
            end
            if (dbg_state == ST_WAIT) begin
                if (prev_state != ST_WAIT) wait_cyc = cyc;
                n_cmp++;
                if (sys_addr !== cur.addr || sys_sel !== 4'hF || (cur.we && sys_wdata !== cur.wdata)) begin
                    n_err++;
                    $display("FAIL wait_hold: addr=%h sel=%h wdata=%h, required addr=%h sel=f wdata=%h",
                             sys_addr, sys_sel, sys_wdata, cur.addr, cur.wdata);
                end
            end
            if (rsp_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    if ({rsp_err, rsp_rdata} !== e[32:0]) begin
                        n_err++;
                        $display("FAIL rsp: err=%b rdata=%h, required err=%b rdata=%h", rsp_err, rsp_rdata, e[32], e[31:0]);
                    end
                    if (e[33]) begin
                        n_cmp++;
                        if (cyc - wait_cyc != TIMEOUT) begin
                            n_err++;
                            $display("FAIL timeout_latency: %0d cycles after WAIT entry, required %0d", cyc - wait_cyc, TIMEOUT);
                        end
                    end
                end
            end
            prev_state = dbg_state;
        end
    end

    // bus responder model
    initial begin
        sys_ack   = 1'b0;
        sys_err   = 1'b0;
        sys_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (plan_q.size() > 0) begin
                tcmd_t p;
                int    g;
                p = plan_q.pop_front();
                if (p.mode != M_NONE) begin
                    for (int i = 0; i < p.delay; i++) @(posedge clk);
                    g = 0;
                    while (stall && g < 5000) begin
                        @(posedge clk);
                        g++;
                    end
                    #1;
                    sys_ack   = (p.mode == M_ACK) || (p.mode == M_BOTH);
                    sys_err   = (p.mode == M_ERR) || (p.mode == M_BOTH);
                    sys_rdata = (p.mode == M_ACK && !p.we) ? p.rdata : $urandom();
                    @(posedge clk);
                    #1;
                    sys_ack   = 1'b0;
                    sys_err   = 1'b0;
                    sys_rdata = $urandom();
                end
            end
        end
    end

    // driver tasks
    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int mode, input int delay);
        tcmd_t c;
        int    g;
        c.we = we; c.addr = addr; c.wdata = wdata; c.rdata = rdata; c.mode = mode; c.delay = delay;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        g = 0;
        while (!cmd_ready && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, g);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        cmd_q.push_back(c);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0 || dbg_state != ST_IDLE) && g < budget) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_cmp++;
        if (g >= budget) begin
            n_err++;
            $display("FAIL drain: %0d responses outstanding after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
            cmd_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_rdata, rsp_err, sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b rdata=%h err=%b addr=%h wdata=%h sel=%h wen=%b ren=%b, required all 0",
                     rsp_valid, rsp_rdata, rsp_err, sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_ready: cmd_ready=%b state=%0d, required 1 and IDLE", cmd_ready, dbg_state);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        send_cmd(1'b1, 32'h4030_0004, 32'h0000_0003, 32'h0, M_ACK, 0);
        wait_idle(200);
    endtask

    task automatic test_read();
        send_cmd(1'b0, 32'h4030_0000, 32'h0, 32'h0000_000A, M_ACK, 0);
        send_cmd(1'b0, 32'h4030_0008, 32'h0, 32'hDEAD_BEEF, M_ACK, 3);
        wait_idle(200);
    endtask

    task automatic test_errors();
        send_cmd(1'b0, 32'h4030_0010, 32'h0, 32'h1234_5678, M_BOTH, 0);
        send_cmd(1'b1, 32'h4030_0014, 32'h55, 32'h0, M_ERR, 1);
        send_cmd(1'b0, 32'h4030_0018, 32'h0, 32'h8765_4321, M_ERR, 0);
        send_cmd(1'b1, 32'h4030_001C, 32'hAA, 32'h0, M_BOTH, 2);
        wait_idle(200);
    endtask

    task automatic test_back_to_back();
        stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_cmd(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), M_ACK, 0);
            n_cmp++;
            if (cmd_ready !== (i < 8)) begin
                n_err++;
                $display("FAIL b2b_ready: after push %0d cmd_ready=%b, required %b", i + 1, cmd_ready, (i < 8));
            end
        end
        stall = 1'b0;
        wait_idle(500);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int r;
            int m;
            r = $urandom_range(0, 9);
            m = (r < 6) ? M_ACK : (r < 8) ? M_ERR : M_BOTH;
            send_cmd(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), m, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle(2000);
    endtask

    task automatic test_reset_mid_wait();
        int g;
        int seen;
        stall = 1'b1;
        send_cmd(1'b0, 32'h4030_0020, 32'h0, 32'hCAFE_F00D, M_ACK, 0);
        g = 0;
        while (dbg_state != ST_WAIT && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_cmp++;
        if (dbg_state !== ST_WAIT) begin
            n_err++;
            $display("FAIL reach_wait: state=%0d, required WAIT", dbg_state);
        end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.delete();
        cmd_q.delete();
        stall = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || sys_wen || sys_ren) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_quiet: %0d cycles with activity after reset, required 0", seen);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL abort_state: cmd_ready=%b state=%0d, required 1 and IDLE", cmd_ready, dbg_state);
        end
        @(posedge clk);
        #1;
        send_cmd(1'b0, 32'h4030_0024, 32'h0, 32'h0BAD_F00D, M_ACK, 0);
        wait_idle(200);
    endtask

`ifdef DSP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        send_cmd(1'b0, 32'h4030_0030, 32'h0, 32'h1111_2222, M_NONE, 0);
        send_cmd(1'b1, 32'h4030_0034, 32'h7, 32'h0, M_ACK, 0);
        wait_idle(1000);
    endtask
`endif

    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
`ifdef DSP_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
